// File: rtl/lsu_bram.sv
// Load/store unit: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests to word-wide bram_rv transactions.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise err instead of being masked.
module lsu_bram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [2:0]            i_req_funct3,
   input  logic [ADDR_WIDTH+1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic [3:0]            o_mem_byte_write_enable,
   output logic                  o_mem_wr_valid,
   input  logic                  i_mem_wr_ready,
   output logic                  o_mem_rd_ready,
   input  logic                  i_mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_t;

   function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return off;
         2'b01:   return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] steer_data(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [3:0] steer_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'd0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   state_t                  state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
   logic [31:0]             data_r, data_nxt_s;
   logic [3:0]              be_r, be_nxt_s;
   logic [2:0]              f3_r;
   logic [1:0]              off_r, off_al_s;
   logic                    err_r, err_nxt_s;
   logic                    accept_s, bad_f3_s, misalign_s, illegal_s;
   logic [31:0]             rdata_s;

   // Request decode, next-state selection and next payload values
   always_comb begin
      accept_s = i_req_valid && (state_r == IDLE);
      off_al_s = align_off(i_req_funct3, i_req_addr[1:0]);
      if (i_req_we) begin
         bad_f3_s = i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11);
      end else begin
         bad_f3_s = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_s = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
      illegal_s  = bad_f3_s || misalign_s;
      addr_nxt_s = accept_s ? i_req_addr[ADDR_WIDTH+1:2] : addr_r;
      data_nxt_s = accept_s ? steer_data(i_req_funct3, i_req_wdata) : data_r;
      be_nxt_s   = accept_s ? steer_be(i_req_funct3, off_al_s) : be_r;
      err_nxt_s  = accept_s ? illegal_s : err_r;
      if ((state_r == RD) && i_mem_rd_valid) begin
         rdata_s = extract(f3_r, off_r, i_mem_data);
      end else begin
         rdata_s = 32'd0;
      end

      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_nxt_s = IDLE;
            end else if (illegal_s) begin
               state_nxt_s = RESP;
            end else if (i_req_we) begin
               state_nxt_s = WR;
            end else begin
               state_nxt_s = RD;
            end
         end
         WR: begin
            if (i_mem_wr_ready) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WR;
            end
         end
         RD: begin
            if (i_mem_rd_valid) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = RD;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, request payload and registered outputs decoded from the next state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r                 <= IDLE;
         addr_r                  <= '0;
         data_r                  <= 32'd0;
         be_r                    <= 4'd0;
         f3_r                    <= 3'd0;
         off_r                   <= 2'd0;
         err_r                   <= 1'b0;
         o_req_ready             <= 1'b1;
         o_mem_wr_valid          <= 1'b0;
         o_mem_rd_ready          <= 1'b0;
         o_mem_addr              <= '0;
         o_mem_data              <= '0;
         o_mem_byte_write_enable <= 4'd0;
         o_resp_valid            <= 1'b0;
         o_resp_err              <= 1'b0;
         o_resp_rdata            <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            addr_r <= addr_nxt_s;
            data_r <= data_nxt_s;
            be_r   <= be_nxt_s;
            f3_r   <= i_req_funct3;
            off_r  <= off_al_s;
            err_r  <= illegal_s;
         end
         o_req_ready             <= (state_nxt_s == IDLE);
         o_mem_wr_valid          <= (state_nxt_s == WR);
         o_mem_rd_ready          <= (state_nxt_s == RD);
         o_mem_addr              <= ((state_nxt_s == WR) || (state_nxt_s == RD)) ? addr_nxt_s : '0;
         o_mem_data              <= (state_nxt_s == WR) ? data_nxt_s : '0;
         o_mem_byte_write_enable <= (state_nxt_s == WR) ? be_nxt_s : 4'd0;
         o_resp_valid            <= (state_nxt_s == RESP);
         o_resp_err              <= (state_nxt_s == RESP) ? err_nxt_s : 1'b0;
         o_resp_rdata            <= (state_nxt_s == RESP) ? rdata_s : '0;
      end
   end

endmodule
